// File: rtl/ring_drain_reader.sv
// ring_drain_reader
//
// Consumer side of a 16-entry circular capture array. The producer writes
// the array on its own; every wr_en pulse tells this block that one entry
// was added. The block keeps a read pointer and an occupancy count. It reads
// the oldest unread entry through the array's combinational read port and
// hands it out on a registered valid/ready stream.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   wr_en         producer wrote an entry this cycle
//   wr_ptr        producer's write address for this cycle (used for sync check)
//   mem_rd_addr   array read address (= rd_ptr, combinational)
//   mem_rd_data   array contents at mem_rd_addr, same cycle
//   m_data        stream data (registered)
//   m_valid       stream valid (registered)
//   m_ready       downstream accepts m_data
//   flush         discard all unread entries and any held output beat
//   clr_err       clear the sticky flags (a same-cycle set wins)
//   level         unread entries in the array, 0..DEPTH
//   overrun       sticky: an unread entry was overwritten by the producer
//   sync_err      sticky: wr_ptr differed from the expected write pointer

module ring_drain_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush,
  input  logic              clr_err,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  output logic              sync_err
);

  // Operating mode, decoded from the registered state each cycle. FLUSH is a
  // one-cycle action, so no separate mode register is kept.
  typedef enum logic [1:0] {
    MODE_IDLE,    // nothing unread and no beat held
    MODE_STREAM,  // data unread or a beat held on the output
    MODE_FLUSH    // flush requested this cycle
  } mode_t;

  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W-1:0] exp_ptr_q,  exp_ptr_d;
  logic [ADDR_W:0]   level_q,    level_d;
  logic [DATA_W-1:0] m_data_q,   m_data_d;
  logic              m_valid_q,  m_valid_d;
  logic              overrun_q,  overrun_d;
  logic              sync_err_q, sync_err_d;

  mode_t mode;
  logic  pop;   // move the oldest unread entry into the output register
  logic  drop;  // producer overwrote the oldest unread entry

  // NOTE: every signal gets a default at the top of this block; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    pop        = 1'b0;
    drop       = 1'b0;

    if (flush)
      mode = MODE_FLUSH;
    else if (level_q == '0 && !m_valid_q)
      mode = MODE_IDLE;
    else
      mode = MODE_STREAM;

    // The expected pointer follows wr_en only; it never resyncs to wr_ptr,
    // so one bad pointer keeps being visible against later writes too.
    exp_ptr_d  = wr_en ? exp_ptr_q + PTR_ONE : exp_ptr_q;

    // Set has priority over clear for both sticky flags.
    sync_err_d = (wr_en && wr_ptr != exp_ptr_q) ? 1'b1
               : (clr_err ? 1'b0 : sync_err_q);
    overrun_d  = clr_err ? 1'b0 : overrun_q;

    case (mode)
      MODE_FLUSH: begin
        // Restart reading at the slot the producer writes this cycle, so a
        // write coincident with the flush is kept as the only entry.
        m_valid_d = 1'b0;
        rd_ptr_d  = exp_ptr_q;
        level_d   = wr_en ? LEVEL_ONE : '0;
      end
      MODE_IDLE: begin
        // Empty: nothing to pop, a write simply makes one entry unread.
        level_d = wr_en ? LEVEL_ONE : '0;
      end
      MODE_STREAM: begin
        pop  = (level_q != '0) && (!m_valid_q || m_ready);
        drop = wr_en && (level_q == LEVEL_FULL) && !pop;

        if (pop) begin
          // The pop samples the array before this edge's write lands, so a
          // full array with a simultaneous write and pop loses nothing.
          m_data_d  = mem_rd_data;
          m_valid_d = 1'b1;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
        end

        if (pop || drop)
          rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (drop)
          overrun_d = 1'b1;  // level stays at DEPTH, oldest entry skipped
        else if (wr_en && !pop)
          level_d = level_q + LEVEL_ONE;
        else if (pop && !wr_en)
          level_d = level_q - LEVEL_ONE;
      end
      default: begin
        // unreachable encoding: hold everything
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      exp_ptr_q  <= '0;
      level_q    <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      exp_ptr_q  <= exp_ptr_d;
      level_q    <= level_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      overrun_q  <= overrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign mem_rd_addr = rd_ptr_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign level       = level_q;
  assign overrun     = overrun_q;
  assign sync_err    = sync_err_q;

endmodule
